// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode-to-execute pipeline register.
//
// Captures the decoded instruction (pc, register specifiers, operand data,
// immediate and control bits) on each rising clk. Incoming writeback data is
// forwarded into the operands so that the execute stage never sees a stale
// register-file read. A load-use hazard is detected combinationally
// (hazard_stall) and turned into a bubble, and bubble_count records those
// bubbles, saturating at 16'hFFFF.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold the stage (operands still pick up writeback data)
//   flush             kill the stage contents
//   in_*              decoded instruction from the decode stage
//   wb_reg_write,
//   wb_rd, wb_data    writeback port, the same one the register file writes
//   out_*             registered instruction presented to execute
//   hazard_stall      combinational load-use indicator, back to upstream
//   bubble_count      registered count of load-use bubbles (saturating)
//
// Update priority per edge: reset > flush > stall > hazard_stall > capture.
module id_ex_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [63:0] in_rdata1,
    input  logic [63:0] in_rdata2,
    input  logic [63:0] in_imm,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_branch,
    input  logic        in_alu_src,
    input  logic        in_mem_to_reg,
    input  logic [1:0]  in_alu_op,
    input  logic [3:0]  in_funct4,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [63:0] out_rdata1,
    output logic [63:0] out_rdata2,
    output logic [63:0] out_imm,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_branch,
    output logic        out_alu_src,
    output logic        out_mem_to_reg,
    output logic [1:0]  out_alu_op,
    output logic [3:0]  out_funct4,
    output logic        hazard_stall,
    output logic [15:0] bubble_count
);

    logic wb_en;
    logic byp_in1, byp_in2;
    logic ref_out1, ref_out2;
    logic kill;
    logic bubble;

    // Load-use: the instruction in this stage loads a register that the
    // instruction waiting in decode wants to read.
    assign hazard_stall = out_valid & out_mem_read & (out_rd != 5'd0) & in_valid &
                          ((out_rd == in_rs1) | (out_rd == in_rs2));

    always_comb begin
        wb_en    = wb_reg_write & (wb_rd != 5'd0);
        byp_in1  = wb_en & (wb_rd == in_rs1);
        byp_in2  = wb_en & (wb_rd == in_rs2);
        // A held instruction keeps listening to writeback so it does not
        // leave the stall with an operand that went stale meanwhile.
        ref_out1 = wb_en & out_valid & (wb_rd == out_rs1);
        ref_out2 = wb_en & out_valid & (wb_rd == out_rs2);
        bubble   = ~stall & hazard_stall;
        kill     = flush | bubble;
    end

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_rdata1     <= '0;
            out_rdata2     <= '0;
            out_imm        <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_branch     <= 1'b0;
            out_alu_src    <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_alu_op     <= '0;
            out_funct4     <= '0;
        end else if (stall) begin
            if (ref_out1) out_rdata1 <= wb_data;
            if (ref_out2) out_rdata2 <= wb_data;
        end else begin
            out_valid      <= in_valid;
            out_pc         <= in_pc;
            out_rs1        <= in_rs1;
            out_rs2        <= in_rs2;
            out_rd         <= in_rd;
            out_rdata1     <= byp_in1 ? wb_data : in_rdata1;
            out_rdata2     <= byp_in2 ? wb_data : in_rdata2;
            out_imm        <= in_imm;
            // Invalid slots still carry their fields but never their effects.
            out_reg_write  <= in_valid & in_reg_write;
            out_mem_read   <= in_valid & in_mem_read;
            out_mem_write  <= in_valid & in_mem_write;
            out_branch     <= in_valid & in_branch;
            out_alu_src    <= in_valid & in_alu_src;
            out_mem_to_reg <= in_valid & in_mem_to_reg;
            out_alu_op     <= in_valid ? in_alu_op : 2'd0;
            out_funct4     <= in_valid ? in_funct4 : 4'd0;
        end
    end

    // Only load-use bubbles count; flush and stall take precedence over them.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (!flush && bubble && (bubble_count != '1)) begin
            bubble_count <= bubble_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        in_valid;
    logic [63:0] in_pc, in_rdata1, in_rdata2, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_reg_write, in_mem_read, in_mem_write, in_branch, in_alu_src, in_mem_to_reg;
    logic [1:0]  in_alu_op;
    logic [3:0]  in_funct4;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        out_valid;
    logic [63:0] out_pc, out_rdata1, out_rdata2, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_alu_src, out_mem_to_reg;
    logic [1:0]  out_alu_op;
    logic [3:0]  out_funct4;
    logic        hazard_stall;
    logic [15:0] bubble_count;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_branch(in_branch), .in_alu_src(in_alu_src), .in_mem_to_reg(in_mem_to_reg),
        .in_alu_op(in_alu_op), .in_funct4(in_funct4),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm(out_imm),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg),
        .out_alu_op(out_alu_op), .out_funct4(out_funct4),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rdata1 = '0; in_rdata2 = '0; in_imm = '0;
        in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_branch = 1'b0;
        in_alu_src = 1'b0; in_mem_to_reg = 1'b0; in_alu_op = '0; in_funct4 = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    initial begin
        idle();
        // Reset overrides a valid incoming instruction
        reset = 1'b1; in_valid = 1'b1; in_pc = 64'hDEAD; in_rdata1 = 64'h77; in_reg_write = 1'b1;
        in_alu_op = 2'd3; in_funct4 = 4'hF; in_rd = 5'd4;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_rdata1", out_rdata1, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_regwr", out_reg_write, 0);
        chk("rst_aluop", out_alu_op, 0);
        chk("rst_bubbles", bubble_count, 0);
        chk("rst_hazard", hazard_stall, 0);

        // Plain capture
        idle();
        in_valid = 1'b1; in_pc = 64'h1000; in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd10;
        in_rdata1 = 64'h11; in_rdata2 = 64'h22; in_imm = 64'h5; in_reg_write = 1'b1;
        in_alu_op = 2'd2; in_funct4 = 4'hA; in_alu_src = 1'b1;
        #1 chk("cap_hazard", hazard_stall, 0);
        tick();
        chk("cap_valid", out_valid, 1);
        chk("cap_rdata1", out_rdata1, 64'h11);
        chk("cap_rdata2", out_rdata2, 64'h22);
        chk("cap_pc", out_pc, 64'h1000);
        chk("cap_rd", out_rd, 10);
        chk("cap_imm", out_imm, 5);
        chk("cap_aluop", out_alu_op, 2);
        chk("cap_funct4", out_funct4, 4'hA);
        chk("cap_regwr", out_reg_write, 1);
        chk("cap_alusrc", out_alu_src, 1);

        // Writeback bypass on rs1
        in_rs1 = 5'd5; in_rdata1 = 64'h0;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 64'hABCD;
        tick();
        chk("byp_rdata1", out_rdata1, 64'hABCD);
        chk("byp_rdata2_nomatch", out_rdata2, 64'h22);

        // Bypass on rs2
        in_rs1 = 5'd6; in_rdata1 = 64'h61; in_rs2 = 5'd5; in_rdata2 = 64'h0;
        tick();
        chk("byp2_rdata1", out_rdata1, 64'h61);
        chk("byp2_rdata2", out_rdata2, 64'hABCD);

        // x0 never bypasses
        in_rs1 = 5'd0; in_rdata1 = 64'h0; in_rs2 = 5'd4; in_rdata2 = 64'h22; wb_rd = 5'd0;
        tick();
        chk("x0_rdata1", out_rdata1, 0);

        // Load-use bubble
        idle();
        in_valid = 1'b1; in_pc = 64'h1100; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd7;
        in_mem_read = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b1;
        tick();
        chk("ld_memrd", out_mem_read, 1);
        chk("ld_rd", out_rd, 7);
        idle();
        in_valid = 1'b1; in_pc = 64'h1104; in_rs1 = 5'd3; in_rs2 = 5'd7; in_rd = 5'd8; in_reg_write = 1'b1;
        #1 chk("lu_hazard", hazard_stall, 1);
        tick();
        chk("lu_valid", out_valid, 0);
        chk("lu_regwr", out_reg_write, 0);
        chk("lu_rd", out_rd, 0);
        chk("lu_bubbles", bubble_count, 1);
        chk("lu_hazard_after", hazard_stall, 0);
        tick();
        chk("lu_resume_valid", out_valid, 1);
        chk("lu_resume_rd", out_rd, 8);
        chk("lu_resume_pc", out_pc, 64'h1104);
        chk("lu_resume_bubbles", bubble_count, 1);

        // Stall refresh of a held operand
        idle();
        in_valid = 1'b1; in_pc = 64'h2000; in_rs1 = 5'd6; in_rs2 = 5'd9; in_rd = 5'd12;
        in_rdata1 = 64'h66; in_rdata2 = 64'h99; in_reg_write = 1'b1; in_funct4 = 4'h3;
        tick();
        chk("st_pre_rdata2", out_rdata2, 64'h99);
        in_pc = 64'hBEEF; in_rdata1 = 64'h1; in_rdata2 = 64'h2; in_rd = 5'd1; in_funct4 = 4'h9;
        stall = 1'b1; wb_reg_write = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_rdata2", out_rdata2, 64'h55);
            chk("st_rdata1", out_rdata1, 64'h66);
            chk("st_pc", out_pc, 64'h2000);
            chk("st_rd", out_rd, 12);
            chk("st_valid", out_valid, 1);
            chk("st_funct4", out_funct4, 4'h3);
            chk("st_regwr", out_reg_write, 1);
        end

        // Flush
        stall = 1'b0; flush = 1'b1; wb_reg_write = 1'b0;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_pc", out_pc, 0);
        chk("fl_rdata2", out_rdata2, 0);
        chk("fl_regwr", out_reg_write, 0);
        chk("fl_funct4", out_funct4, 0);
        chk("fl_bubbles", bubble_count, 1);

        // Stall beats hazard: held, no count
        idle();
        in_valid = 1'b1; in_pc = 64'h3000; in_rd = 5'd7; in_mem_read = 1'b1; in_reg_write = 1'b1;
        tick();
        in_pc = 64'h3004; in_rs1 = 5'd7; in_rd = 5'd2; in_mem_read = 1'b0; stall = 1'b1;
        #1 chk("sh_hazard", hazard_stall, 1);
        tick();
        chk("sh_valid", out_valid, 1);
        chk("sh_pc", out_pc, 64'h3000);
        chk("sh_bubbles", bubble_count, 1);

        // Flush + stall + hazard: flush wins, no count
        flush = 1'b1;
        #1 chk("fsh_hazard", hazard_stall, 1);
        tick();
        chk("fsh_valid", out_valid, 0);
        chk("fsh_bubbles", bubble_count, 1);

        // Invalid capture: fields load, controls forced 0
        idle();
        in_pc = 64'h3100; in_rd = 5'd13; in_imm = 64'h42; in_reg_write = 1'b1; in_mem_write = 1'b1;
        in_mem_read = 1'b1; in_branch = 1'b1; in_alu_op = 2'd3; in_funct4 = 4'h5;
        tick();
        chk("iv_valid", out_valid, 0);
        chk("iv_pc", out_pc, 64'h3100);
        chk("iv_rd", out_rd, 13);
        chk("iv_imm", out_imm, 64'h42);
        chk("iv_memwr", out_mem_write, 0);
        chk("iv_memrd", out_mem_read, 0);
        chk("iv_branch", out_branch, 0);
        chk("iv_aluop", out_alu_op, 0);
        chk("iv_funct4", out_funct4, 0);

        // Reset mid-stall discards held instruction
        idle();
        in_valid = 1'b1; in_pc = 64'h3200; in_rd = 5'd3; in_reg_write = 1'b1;
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        chk("rs_valid", out_valid, 0);
        chk("rs_pc", out_pc, 0);
        chk("rs_bubbles", bubble_count, 0);
        reset = 1'b0; stall = 1'b0; in_pc = 64'h4000;
        tick();
        chk("rs_cap_valid", out_valid, 1);
        chk("rs_cap_pc", out_pc, 64'h4000);

        // Saturation: a permanent load-use pair alternates capture / bubble
        idle();
        reset = 1'b1;
        in_valid = 1'b1; in_rs1 = 5'd7; in_rd = 5'd7; in_mem_read = 1'b1; in_reg_write = 1'b1;
        tick();
        chk("sat_hazard_after_rst", hazard_stall, 0);
        reset = 1'b0;
        for (int i = 0; i < 2 * 65534; i++) @(posedge clk);
        #1 chk("sat_fffe", bubble_count, 16'hFFFE);
        for (int i = 0; i < 2; i++) @(posedge clk);
        #1 chk("sat_ffff", bubble_count, 16'hFFFF);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1 chk("sat_hold", bubble_count, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
